spi_reg_peripheral: RTL
=======================

// Module: spi_reg_peripheral
// PURPOSE
//   SPI (mode 0) write-only register slave feeding the PWM stage of UWASIC_Shiheng.
//   Samples SCLK/COPI/nCS from ui_in[0..2] in the clk domain and assembles 16-bit frames.
//   Commits valid frames into five 8-bit control registers consumed by the downstream PWM block.
// PARAMETERS
//   SYNC_STAGES  2   flops per input synchronizer chain (>=2)
//   MAX_ADDR     4   highest writable register address; higher addresses are ignored
// PORTS
//   clk              in   1  system clock
//   rst_n            in   1  asynchronous active-low reset
//   sclk_i           in   1  SPI clock (ui_in[0]), asynchronous to clk
//   copi_i           in   1  SPI data in (ui_in[1])
//   ncs_i            in   1  SPI chip select, active low (ui_in[2])
//   en_reg_out_7_0   out  8  addr 0x00: output enables uo_out[7:0]
//   en_reg_out_15_8  out  8  addr 0x01: output enables uio_out[7:0]
//   en_reg_pwm_7_0   out  8  addr 0x02: PWM mode select uo_out[7:0]
//   en_reg_pwm_15_8  out  8  addr 0x03: PWM mode select uio_out[7:0]
//   pwm_duty_cycle   out  8  addr 0x04: duty (0x00 = 0%, 0xFF = 100%)
//   commit_o         out  1  1-cycle pulse: a register was written this cycle
//   frame_err_o      out  1  1-cycle pulse: frame discarded (bad length)
// BEHAVIOUR
//   Reset: one clock domain; async active-low rst_n clears all five registers, commit_o,
//     frame_err_o, synchronizers (to nCS=1, SCLK=0, COPI=0), shift register, bit counter, FSM.
//   Sync: each input passes through SYNC_STAGES flops plus one history flop for edge detect.
//     SCLK and nCS must each hold every level for >= SYNC_STAGES+2 clk periods.
//   FSM IDLE -> SHIFT on synced nCS falling edge: clear 5-bit bit_cnt and shift register.
//   SHIFT: on each synced SCLK rising edge, shift_reg <= {shift_reg[14:0], copi_sync};
//     bit_cnt increments and saturates at 31. SCLK falling edges are ignored.
//   SHIFT -> COMMIT on synced nCS rising edge. SCLK edges coincident with it are dropped.
//   COMMIT (exactly one cycle), then always -> IDLE:
//     - bit_cnt != 16: frame_err_o=1, no register change.
//     - bit_cnt == 16, frame = {rw[15], addr[14:8], data[7:0]}:
//       rw=1 and addr<=MAX_ADDR writes data to that register; commit_o=1.
//       rw=0 (read) or addr>MAX_ADDR: silently dropped, no pulse.
//   The written value appears on its output port on the clk edge ending COMMIT, i.e.
//     SYNC_STAGES+2 clk cycles after the nCS pin rises; the value then holds until the
//     next write or reset.
//   In IDLE, SCLK/COPI activity is ignored. nCS falling during COMMIT is seen in IDLE
//     on the following cycle; no edge is lost (edge detect is registered).
//   Reset mid-frame discards the partial frame. The first frame after reset needs a fresh
//     nCS falling edge.
//   Registers not addressed by a write are never disturbed. Outputs change only in COMMIT.
// TESTING
//   1 Reset: hold rst_n=0 with SPI lines toggling -> all five regs 0x00, no pulses.
//   2 Write 0x80_F0 (addr 0, data 0xF0), SCLK=clk/10 -> en_reg_out_7_0=0xF0,
//     one commit_o pulse, other regs still 0x00.
//   3 Write 0x84_80, then 0x84_FF -> pwm_duty_cycle reads 0x80, then 0xFF.
//     Back-to-back frames need only the minimum nCS high time.
//   4 Read 0x00_55 and write to addr 0x05/0x7F -> no register change, no commit_o, no frame_err_o.
//   5 15-bit and 17-bit frames to addr 2 -> frame_err_o pulse, en_reg_pwm_7_0 unchanged.
//   6 rst_n asserted after 8 bits of 0x83_AA, then a full 0x83_AA frame after release
//     -> no write from the aborted frame, then en_reg_pwm_15_8=0xAA.

Source files
------------

// File: rtl/spi_reg_peripheral.sv
// ============================================================================
// spi_reg_peripheral : SPI mode-0 write-only slave, 16-bit frames -> 5 control regs
// Rev 1.0
// ============================================================================
`default_nettype none

module spi_reg_peripheral #(
   parameter int SYNC_STAGES = 2,
   parameter int MAX_ADDR    = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sclk_i,
   input  logic       copi_i,
   input  logic       ncs_i,
   output logic [7:0] en_reg_out_7_0,
   output logic [7:0] en_reg_out_15_8,
   output logic [7:0] en_reg_pwm_7_0,
   output logic [7:0] en_reg_pwm_15_8,
   output logic [7:0] pwm_duty_cycle,
   output logic       commit_o,
   output logic       frame_err_o
);

   localparam logic [1:0] c_ST_IDLE   = 2'd0;
   localparam logic [1:0] c_ST_SHIFT  = 2'd1;
   localparam logic [1:0] c_ST_COMMIT = 2'd2;

   logic [SYNC_STAGES-1:0] r_sclk_sy, r_copi_sy, r_ncs_sy;
   logic                   r_sclk_d, r_ncs_d;
   logic [1:0]             r_state, w_next;
   logic [15:0]            r_shift;
   logic [4:0]             r_bit_cnt;
   logic                   r_fall_pend;
   logic                   w_sclk_rise, w_ncs_fall, w_ncs_rise, w_copi;
   logic                   w_len_ok, w_write_en;
   logic [6:0]             w_addr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sclk_sy <= '0;
         r_copi_sy <= '0;
         r_ncs_sy  <= '1;
         r_sclk_d  <= 1'b0;
         r_ncs_d   <= 1'b1;
      end else begin
         r_sclk_sy <= {r_sclk_sy[SYNC_STAGES-2:0], sclk_i};
         r_copi_sy <= {r_copi_sy[SYNC_STAGES-2:0], copi_i};
         r_ncs_sy  <= {r_ncs_sy[SYNC_STAGES-2:0], ncs_i};
         r_sclk_d  <= r_sclk_sy[SYNC_STAGES-1];
         r_ncs_d   <= r_ncs_sy[SYNC_STAGES-1];
      end
   end

   assign w_sclk_rise = r_sclk_sy[SYNC_STAGES-1] & ~r_sclk_d;
   assign w_ncs_fall  = ~r_ncs_sy[SYNC_STAGES-1] & r_ncs_d;
   assign w_ncs_rise  = r_ncs_sy[SYNC_STAGES-1] & ~r_ncs_d;
   assign w_copi      = r_copi_sy[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= c_ST_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         c_ST_IDLE:   if (w_ncs_fall || r_fall_pend) w_next = c_ST_SHIFT;
         c_ST_SHIFT:  if (w_ncs_rise) w_next = c_ST_COMMIT;
         c_ST_COMMIT: w_next = c_ST_IDLE;
         default:     w_next = c_ST_IDLE;
      endcase
   end

   assign w_addr   = r_shift[14:8];
   assign w_len_ok = (r_bit_cnt == 5'd16);

   always_comb begin
      commit_o    = 1'b0;
      frame_err_o = 1'b0;
      w_write_en  = 1'b0;
      if (r_state == c_ST_COMMIT) begin
         frame_err_o = ~w_len_ok;
         w_write_en  = w_len_ok & r_shift[15] & (w_addr <= 7'(MAX_ADDR));
         commit_o    = w_write_en;
      end
   end

   // A falling nCS seen during COMMIT is held so IDLE still starts the next frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shift     <= '0;
         r_bit_cnt   <= '0;
         r_fall_pend <= 1'b0;
      end else begin
         case (r_state)
            c_ST_IDLE: begin
               r_fall_pend <= 1'b0;
               if (w_ncs_fall || r_fall_pend) begin
                  r_shift   <= '0;
                  r_bit_cnt <= '0;
               end
            end
            c_ST_SHIFT: begin
               if (!w_ncs_rise && w_sclk_rise) begin
                  r_shift <= {r_shift[14:0], w_copi};
                  if (r_bit_cnt != 5'd31) r_bit_cnt <= r_bit_cnt + 5'd1;
               end
            end
            c_ST_COMMIT: r_fall_pend <= w_ncs_fall;
            default:     r_fall_pend <= 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_reg_out_7_0  <= '0;
         en_reg_out_15_8 <= '0;
         en_reg_pwm_7_0  <= '0;
         en_reg_pwm_15_8 <= '0;
         pwm_duty_cycle  <= '0;
      end else if (w_write_en) begin
         case (w_addr)
            7'd0:    en_reg_out_7_0  <= r_shift[7:0];
            7'd1:    en_reg_out_15_8 <= r_shift[7:0];
            7'd2:    en_reg_pwm_7_0  <= r_shift[7:0];
            7'd3:    en_reg_pwm_15_8 <= r_shift[7:0];
            7'd4:    pwm_duty_cycle  <= r_shift[7:0];
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire
